// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter sharing one CORDIC core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ANGLE_WIDTH = 32,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]       req_x,
    input  logic [NUM_REQ*WIDTH-1:0]       req_y,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [WIDTH-1:0]               rsp_cos,
    output logic [WIDTH-1:0]               rsp_sin,
    output logic                           rsp_err,
    output logic                           core_start,
    output logic [WIDTH-1:0]               core_x,
    output logic [WIDTH-1:0]               core_y,
    output logic [ANGLE_WIDTH-1:0]         core_angle,
    input  logic [WIDTH-1:0]               core_cos,
    input  logic [WIDTH-1:0]               core_sin,
    input  logic                           core_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   granted;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [NUM_REQ-1:0] gnt_onehot;
    int unsigned        cand;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             rsp_err_r;
    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

    // Search starts one past the last grant so every requester is reached within NUM_REQ grants.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant) + k) % NUM_REQ;
            if (!sel_found && req_valid[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        gnt_onehot = '0;
        sel_onehot[sel_idx] = 1'b1;
        gnt_onehot[granted] = 1'b1;
    end

    assign req_ready = (state == IDLE && sel_found) ? sel_onehot : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            granted    <= '0;
            core_start <= 1'b0;
            core_x     <= '0;
            core_y     <= '0;
            core_angle <= '0;
            rsp_valid  <= '0;
            rsp_cos    <= '0;
            rsp_sin    <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            rsp_err_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        core_x     <= req_x[32'(sel_idx)*WIDTH +: WIDTH];
                        core_y     <= req_y[32'(sel_idx)*WIDTH +: WIDTH];
                        core_angle <= req_angle[32'(sel_idx)*ANGLE_WIDTH +: ANGLE_WIDTH];
                        granted    <= sel_idx;
                        last_grant <= sel_idx;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done pulse in the expiry cycle takes precedence over the timeout.
                    if (core_done) begin
                        rsp_cos   <= core_cos;
                        rsp_sin   <= core_sin;
                        rsp_valid <= gnt_onehot;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        rsp_err_r <= 1'b0;
`endif
                        state     <= RESPOND;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_cos   <= '0;
                        rsp_sin   <= '0;
                        rsp_err_r <= 1'b1;
                        rsp_valid <= gnt_onehot;
                        state     <= RESPOND;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed self-checking bench for cordic_req_arbiter (4 requesters).
// Watchdog scenarios are compiled only when CORDIC_ARB_TIMEOUT_EN is defined.
module tb_cordic_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned AW = 32;
`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 64;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_x, req_y;
    logic [NR*AW-1:0] req_angle;
    logic [NR-1:0]   rsp_valid;
    logic [W-1:0]    rsp_cos, rsp_sin;
    logic            rsp_err;
    logic            core_start;
    logic [W-1:0]    core_x, core_y;
    logic [AW-1:0]   core_angle;
    logic [W-1:0]    core_cos, core_sin;
    logic            core_done;

    int n_checks = 0;
    int n_errors = 0;

    cordic_req_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ANGLE_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
        .rsp_valid(rsp_valid), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err),
        .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_angle(core_angle),
        .core_cos(core_cos), .core_sin(core_sin), .core_done(core_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_defaults();
        for (int i = 0; i < NR; i++) begin
            req_x[i*W +: W]      = 16'h1000 + 16'(i);
            req_y[i*W +: W]      = 16'h2000 + 16'(i);
            req_angle[i*AW +: AW] = 32'hA000_0000 + 32'(i);
        end
    endtask

    // Full transaction with a core latency of lat WAIT cycles; expects grant exp_g.
    task automatic do_txn(input int exp_g, input int lat, input logic [W-1:0] c, input logic [W-1:0] s);
        logic found;
        logic [NR-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[exp_g] = 1'b1;
        #1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (req_ready != '0) found = 1'b1;
            else tick();
        end
        check("ready_seen", 64'(found), 64'd1);
        check("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        check("grant", 64'(req_ready), 64'(exp_oh));
        tick();
        check("issue_start", 64'(core_start), 64'd1);
        check("issue_ready", 64'(req_ready), 64'd0);
        check("core_x", 64'(core_x), 64'(req_x[exp_g*W +: W]));
        check("core_angle", 64'(core_angle), 64'(req_angle[exp_g*AW +: AW]));
        tick();
        check("wait_start", 64'(core_start), 64'd0);
        repeat (lat - 1) tick();
        core_done = 1'b1; core_cos = c; core_sin = s;
        tick();
        core_done = 1'b0;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_oh));
        check("rsp_cos", 64'(rsp_cos), 64'(c));
        check("rsp_sin", 64'(rsp_sin), 64'(s));
        check("rsp_err", 64'(rsp_err), 64'd0);
        tick();
        check("rsp_clear", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_angle = '0;
        core_cos = '0; core_sin = '0; core_done = 1'b0;
        repeat (3) tick();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_start", 64'(core_start), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_core_x", 64'(core_x), 64'd0);
        reset = 1'b0;
        tick();

        // Single request from requester 2, core answers after 17 cycles.
        req_angle[2*AW +: AW] = 32'h3243_F6A9;
        req_x[2*W +: W] = 16'h4DBA;
        req_y[2*W +: W] = 16'h0000;
        req_valid = 4'b0100;
        #1;
        check("s1_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        check("s1_start", 64'(core_start), 64'd1);
        check("s1_angle", 64'(core_angle), 64'h3243_F6A9);
        check("s1_x", 64'(core_x), 64'h4DBA);
        check("s1_y", 64'(core_y), 64'h0);
        tick();
        check("s1_start_low", 64'(core_start), 64'd0);
        for (int k = 0; k < 16; k++) begin
            check("s1_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        core_done = 1'b1; core_cos = 16'h0000; core_sin = 16'h4DBA;
        tick();
        core_done = 1'b0; core_cos = 16'hFFFF; core_sin = 16'hFFFF;
        check("s1_rsp_valid", 64'(rsp_valid), 64'h4);
        check("s1_rsp_cos", 64'(rsp_cos), 64'h0000);
        check("s1_rsp_sin", 64'(rsp_sin), 64'h4DBA);
        tick();
        check("s1_rsp_clear", 64'(rsp_valid), 64'd0);
        check("s1_hold_sin", 64'(rsp_sin), 64'h4DBA);

        // Stray core_done while idle must not produce a response.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("idle_done_ignored", 64'(rsp_valid), 64'd0);

        // Re-reset so grant order starts from requester 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_defaults();
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++)
            do_txn(t % 4, 2, 16'h0100 + 16'(t), 16'h0200 + 16'(t));
        req_valid = '0;

        // Serve 1, then 1 and 3 together: 3 is next after 1.
        req_valid = 4'b0010;
        do_txn(1, 3, 16'h1111, 16'h2222);
        req_valid = 4'b1010;
        do_txn(3, 1, 16'h3333, 16'h4444);
        req_valid = '0;

        // Reset during WAIT of a requester-2 transaction, then a late core_done.
        req_valid = 4'b0100;
        #1;
        check("s4_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("s4_rst_start", 64'(core_start), 64'd0);
        check("s4_rst_rsp", 64'(rsp_valid), 64'd0);
        check("s4_rst_cos", 64'(rsp_cos), 64'd0);
        check("s4_rst_core_x", 64'(core_x), 64'd0);
        check("s4_rst_angle", 64'(core_angle), 64'd0);
        tick();
        reset = 1'b0;
        core_done = 1'b1; core_cos = 16'h5555; core_sin = 16'h6666;
        tick();
        core_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("s4_no_rsp", 64'(rsp_valid), 64'd0);
            check("s4_cos_held", 64'(rsp_cos), 64'd0);
            tick();
        end
        req_valid = 4'b1111;
        do_txn(0, 2, 16'h7777, 16'h8888);
        req_valid = '0;

`ifdef CORDIC_ARB_TIMEOUT_EN
        // Core never answers: timeout response at WAIT cycle 8.
        req_valid = 4'b0010;
        #1;
        check("to_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        for (int k = 1; k < 8; k++) begin
            check("to_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        tick();
        check("to_rsp_valid", 64'(rsp_valid), 64'h2);
        check("to_err", 64'(rsp_err), 64'd1);
        check("to_cos", 64'(rsp_cos), 64'd0);
        check("to_sin", 64'(rsp_sin), 64'd0);
        tick();
        check("to_err_held", 64'(rsp_err), 64'd1);

        // Done in exactly WAIT cycle 8 wins over the timeout.
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        tick();
        repeat (7) tick();
        core_done = 1'b1; core_cos = 16'h0ABC; core_sin = 16'h0DEF;
        tick();
        core_done = 1'b0;
        check("race_rsp_valid", 64'(rsp_valid), 64'h4);
        check("race_err", 64'(rsp_err), 64'd0);
        check("race_cos", 64'(rsp_cos), 64'h0ABC);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
